// File: rtl/interrupt_ack_sequencer_if.sv
// rtl/interrupt_ack_sequencer_if.sv - resolver/CPU-facing signal bundle of the INTA sequencer
interface interrupt_ack_sequencer_if;
  logic [7:0] interrupt;
  logic       inta_strobe;
  logic [4:0] vector_base;
  logic       aeoi_mode;
  logic       auto_rotate;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] clear_irr;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output interrupt, inta_strobe, vector_base, aeoi_mode, auto_rotate,
           eoi_valid, eoi_specific, eoi_level, eoi_rotate,
    input  int_out, in_service_register, priority_rotate, clear_irr,
           data_out, data_out_en
  );

  modport slave (
    input  interrupt, inta_strobe, vector_base, aeoi_mode, auto_rotate,
           eoi_valid, eoi_specific, eoi_level, eoi_rotate,
    output int_out, in_service_register, priority_rotate, clear_irr,
           data_out, data_out_en
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// rtl/interrupt_ack_sequencer.sv - two-pulse INTA sequencer owning ISR, vector drive and EOI rotation
module interrupt_ack_sequencer #(
  parameter int NUM_LEVELS = 8
) (
  input logic                      clk,
  input logic                      rst,
  interrupt_ack_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_e;

  state_e     state_q;
  logic [2:0] level_q;
  logic       spurious_q;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic       int_out_q;
  logic [7:0] clear_irr_q;
  logic [7:0] data_out_q;
  logic       data_out_en_q;

  logic [2:0] req_level;
  logic       ns_found;
  logic [2:0] ns_level;
  logic [2:0] ns_idx;
  logic [7:0] eoi_clr;
  logic       eoi_rot_en;
  logic [2:0] eoi_rot_level;
  logic [7:0] ack_set;
  logic       aeoi_fire;
  logic [7:0] aeoi_clr;

  always_comb begin
    req_level = 3'd7;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (bus.interrupt[i]) req_level = 3'(i);
    end
  end

  // Scan lowest to highest priority so the last hit is the highest-priority set bit.
  always_comb begin
    ns_found = 1'b0;
    ns_level = 3'd0;
    ns_idx   = 3'd0;
    for (int k = NUM_LEVELS; k >= 1; k--) begin
      ns_idx = rot_q + 3'(k);
      if (isr_q[ns_idx]) begin
        ns_found = 1'b1;
        ns_level = ns_idx;
      end
    end
  end

  always_comb begin
    eoi_clr       = 8'd0;
    eoi_rot_en    = 1'b0;
    eoi_rot_level = bus.eoi_level;
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        eoi_clr    = 8'd1 << bus.eoi_level;
        eoi_rot_en = bus.eoi_rotate;
      end else if (ns_found) begin
        eoi_clr       = 8'd1 << ns_level;
        eoi_rot_en    = bus.eoi_rotate;
        eoi_rot_level = ns_level;
      end
    end
  end

  always_comb begin
    ack_set   = 8'd0;
    aeoi_fire = (state_q == ACK2) && bus.inta_strobe && bus.aeoi_mode && !spurious_q;
    aeoi_clr  = aeoi_fire ? (8'd1 << level_q) : 8'd0;
    if ((state_q == ACK1) && bus.inta_strobe && (bus.interrupt != 8'd0)) begin
      ack_set = 8'd1 << req_level;
    end
    // The ack set is ORed in last so a same-cycle EOI never removes the bit being acknowledged.
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_set;
    if (eoi_rot_en)                        rot_d = eoi_rot_level;
    else if (aeoi_fire && bus.auto_rotate) rot_d = level_q;
    else                                   rot_d = rot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      level_q       <= 3'd0;
      spurious_q    <= 1'b0;
      isr_q         <= 8'd0;
      rot_q         <= 3'b111;
      int_out_q     <= 1'b0;
      clear_irr_q   <= 8'd0;
      data_out_q    <= 8'd0;
      data_out_en_q <= 1'b0;
    end else begin
      isr_q         <= isr_d;
      rot_q         <= rot_d;
      clear_irr_q   <= 8'd0;
      data_out_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.interrupt != 8'd0) begin
            int_out_q <= 1'b1;
            state_q   <= ACK1;
          end
        end
        ACK1: begin
          if (bus.inta_strobe) begin
            int_out_q <= 1'b0;
            state_q   <= ACK2;
            if (bus.interrupt != 8'd0) begin
              level_q     <= req_level;
              spurious_q  <= 1'b0;
              clear_irr_q <= ack_set;
            end else begin
              level_q    <= 3'd7;
              spurious_q <= 1'b1;
            end
          end
        end
        ACK2: begin
          if (bus.inta_strobe) begin
            data_out_q    <= {bus.vector_base, level_q};
            data_out_en_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.int_out             = int_out_q;
  assign bus.in_service_register = isr_q;
  assign bus.priority_rotate     = rot_q;
  assign bus.clear_irr           = clear_irr_q;
  assign bus.data_out            = data_out_q;
  assign bus.data_out_en         = data_out_en_q;

endmodule
